// File: rtl/keypoint_reader_if.sv
// Keypoint stream from keypoint_reader to its consumer: (x, y) coordinates
// with a valid/ready handshake.
interface keypoint_reader_if #(
    parameter int L = 6
);
    logic [L-1:0] kp_x;
    logic [L-1:0] kp_y;
    logic         kp_valid;
    logic         kp_ready;

    modport master (
        output kp_x,
        output kp_y,
        output kp_valid,
        input  kp_ready
    );

    modport slave (
        input  kp_x,
        input  kp_y,
        input  kp_valid,
        output kp_ready
    );
endinterface

// File: rtl/keypoint_reader.sv
// Walks the keypoint BRAM, decodes each {present, y, x} entry and streams the
// present ones out as (x, y) pairs over a valid/ready handshake.
module keypoint_reader #(
    parameter int DIMENSION = 64,
    parameter int ADDR_W    = $clog2(DIMENSION*DIMENSION),
    localparam int L        = $clog2(DIMENSION)
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    start,
    input  logic [ADDR_W:0]         keypoint_count,
    output logic [ADDR_W-1:0]       key_read_addr,
    input  logic [2*L:0]            key_data,
    keypoint_reader_if.master       kp,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W:0]         emitted_count
);

    localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W+1)'(DIMENSION*DIMENSION);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        CAPTURE,
        PRESENT,
        ADVANCE,
        DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_emitted;
    logic [L-1:0]      r_kp_x;
    logic [L-1:0]      r_kp_y;
    logic              r_kp_valid;
    logic              r_busy;
    logic              r_done;

    logic [ADDR_W:0]   w_last_addr;
    logic              w_at_last;

    assign w_last_addr = r_count - (ADDR_W+1)'(1);
    assign w_at_last   = ({1'b0, r_addr} == w_last_addr);

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_count    <= '0;
            r_emitted  <= '0;
            r_kp_x     <= '0;
            r_kp_y     <= '0;
            r_kp_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_emitted <= '0;
                        if (keypoint_count == '0) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_count <= (keypoint_count > MAX_COUNT) ? MAX_COUNT : keypoint_count;
                            r_addr  <= '0;
                            r_busy  <= 1'b1;
                            r_state <= FETCH;
                        end
                    end
                end
                FETCH:   r_state <= WAIT;
                // BRAM has two output registers, so data for r_addr lands here
                WAIT:    r_state <= CAPTURE;
                CAPTURE: begin
                    r_kp_x <= key_data[L-1:0];
                    r_kp_y <= key_data[2*L-1:L];
                    if (key_data[2*L]) begin
                        r_kp_valid <= 1'b1;
                        r_state    <= PRESENT;
                    end else begin
                        r_state <= ADVANCE;
                    end
                end
                PRESENT: begin
                    if (r_kp_valid && kp.kp_ready) begin
                        r_kp_valid <= 1'b0;
                        r_emitted  <= r_emitted + (ADDR_W+1)'(1);
                        r_state    <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (w_at_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_state <= FETCH;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign key_read_addr = r_addr;
    assign kp.kp_x       = r_kp_x;
    assign kp.kp_y       = r_kp_y;
    assign kp.kp_valid   = r_kp_valid;
    assign busy          = r_busy;
    assign done          = r_done;
    assign emitted_count = r_emitted;

endmodule

// File: tb/tb_keypoint_reader.sv
// Directed bench for keypoint_reader at DIMENSION=4 with a two-stage BRAM model.
module tb_keypoint_reader;

    localparam int DIMENSION = 4;
    localparam int L         = 2;
    localparam int ADDR_W    = 4;

    logic              clk = 1'b0;
    logic              rst_in = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   keypoint_count = '0;
    logic [ADDR_W-1:0] key_read_addr;
    logic [2*L:0]      key_data;
    logic [2*L:0]      bram_p0;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   emitted_count;
    logic [2*L:0]      mem [16];

    int checks = 0;
    int errors = 0;
    int n_hs, n_done, done_cyc, first_valid;
    logic busy_seen, busy_c1;
    int hs_x [8];
    int hs_y [8];

    keypoint_reader_if #(.L(L)) kp ();

    keypoint_reader #(.DIMENSION(DIMENSION)) dut (
        .clk            (clk),
        .rst_in         (rst_in),
        .start          (start),
        .keypoint_count (keypoint_count),
        .key_read_addr  (key_read_addr),
        .key_data       (key_data),
        .kp             (kp.master),
        .busy           (busy),
        .done           (done),
        .emitted_count  (emitted_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bram_p0  <= mem[key_read_addr];
        key_data <= bram_p0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout need finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load3(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = a;
        mem[1] = b;
        mem[2] = c;
    endtask

    // Leaves the bench #1 after edge 0, i.e. inside cycle 1.
    task automatic do_start(input int count);
        @(negedge clk);
        keypoint_count = count[ADDR_W:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run(input int stall, input int restart_cyc, input int max_cyc);
        int stall_left;
        int tail;
        logic pend;
        int hx, hy, ha;
        n_hs = 0; n_done = 0; done_cyc = -1; first_valid = -1;
        busy_seen = 1'b0; busy_c1 = 1'b0;
        stall_left = stall; pend = 1'b0; tail = -1;
        hx = 0; hy = 0; ha = 0;
        for (int k = 1; k <= max_cyc && tail != 0; k++) begin
            if (k == 1) busy_c1 = busy;
            if (busy) busy_seen = 1'b1;
            if (restart_cyc != 0) start = (k == restart_cyc);
            if (pend) begin
                check_val("hold_valid", kp.kp_valid, 1);
                check_val("hold_x", kp.kp_x, hx);
                check_val("hold_y", kp.kp_y, hy);
                check_val("hold_addr", key_read_addr, ha);
            end
            if (kp.kp_valid && first_valid < 0) first_valid = k;
            kp.kp_ready = (stall_left == 0);
            if (kp.kp_valid && !kp.kp_ready) begin
                stall_left--;
                pend = 1'b1;
                hx = kp.kp_x; hy = kp.kp_y; ha = key_read_addr;
            end else begin
                pend = 1'b0;
            end
            if (kp.kp_valid && kp.kp_ready && n_hs < 8) begin
                hs_x[n_hs] = kp.kp_x;
                hs_y[n_hs] = kp.kp_y;
                n_hs++;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    check_val("busy_at_done", busy, 0);
                    tail = 4;
                end
            end
            if (tail > 0) tail--;
            @(posedge clk);
            #1;
        end
        kp.kp_ready = 1'b1;
        start = 1'b0;
        if (done_cyc < 0) check_val("done_seen", 0, 1);
    endtask

    task automatic check_three(input string tag, input int exp_done);
        check_val({tag, "_first_valid"}, first_valid, 4);
        check_val({tag, "_busy_c1"}, busy_c1, 1);
        check_val({tag, "_n_hs"}, n_hs, 3);
        check_val({tag, "_x0"}, hs_x[0], 3);
        check_val({tag, "_y0"}, hs_y[0], 2);
        check_val({tag, "_x1"}, hs_x[1], 0);
        check_val({tag, "_y1"}, hs_y[1], 0);
        check_val({tag, "_x2"}, hs_x[2], 3);
        check_val({tag, "_y2"}, hs_y[2], 1);
        check_val({tag, "_done_cyc"}, done_cyc, exp_done);
        check_val({tag, "_n_done"}, n_done, 1);
        check_val({tag, "_emitted"}, emitted_count, 3);
        check_val({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        kp.kp_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_in = 1'b0;
        check_val("rst_addr", key_read_addr, 0);
        check_val("rst_x", kp.kp_x, 0);
        check_val("rst_y", kp.kp_y, 0);
        check_val("rst_valid", kp.kp_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_emitted", emitted_count, 0);

        // Count 0: done in cycle 1, nothing presented, never busy
        do_start(0);
        run(0, 0, 10);
        check_val("c0_done_cyc", done_cyc, 1);
        check_val("c0_first_valid", first_valid, -1);
        check_val("c0_busy_seen", busy_seen, 0);
        check_val("c0_emitted", emitted_count, 0);
        check_val("c0_n_done", n_done, 1);

        // Three present entries, ready high
        load3(5'h1B, 5'h10, 5'h17);
        do_start(3);
        run(0, 0, 60);
        check_three("three", 16);

        // First keypoint held off for 7 cycles
        do_start(3);
        run(7, 0, 80);
        check_three("stall", 23);

        // Entry 0 has no present flag and is skipped
        load3(5'h0B, 5'h1B, 5'h00);
        do_start(2);
        run(0, 0, 60);
        check_val("skip_n_hs", n_hs, 1);
        check_val("skip_x", hs_x[0], 3);
        check_val("skip_y", hs_y[0], 2);
        check_val("skip_first_valid", first_valid, 8);
        check_val("skip_done_cyc", done_cyc, 10);
        check_val("skip_emitted", emitted_count, 1);

        // Second start pulsed during WAIT must be ignored
        load3(5'h1B, 5'h10, 5'h17);
        do_start(3);
        run(0, 2, 60);
        check_three("rebusy", 16);
        check_val("rebusy_done_end", done, 0);

        // Async reset while the second keypoint is being presented
        do_start(3);
        for (int k = 1; k < 9; k++) begin
            if (k == 5) kp.kp_ready = 1'b0;
            @(posedge clk);
            #1;
        end
        check_val("mid_valid_pre", kp.kp_valid, 1);
        check_val("mid_emitted_pre", emitted_count, 1);
        check_val("mid_addr_pre", key_read_addr, 1);
        #2;
        rst_in = 1'b1;
        #1;
        check_val("mid_valid_rst", kp.kp_valid, 0);
        check_val("mid_busy_rst", busy, 0);
        check_val("mid_emitted_rst", emitted_count, 0);
        check_val("mid_addr_rst", key_read_addr, 0);
        check_val("mid_done_rst", done, 0);
        @(negedge clk);
        rst_in = 1'b0;
        kp.kp_ready = 1'b1;
        do_start(3);
        run(0, 0, 60);
        check_three("replay", 16);

        // Count above DIMENSION*DIMENSION clamps to 16 entries
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[15] = 5'h1F;
        do_start(20);
        run(0, 0, 120);
        check_val("clamp_n_hs", n_hs, 1);
        check_val("clamp_x", hs_x[0], 3);
        check_val("clamp_y", hs_y[0], 3);
        check_val("clamp_first_valid", first_valid, 64);
        check_val("clamp_done_cyc", done_cyc, 66);
        check_val("clamp_emitted", emitted_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypoint_reader.md
# keypoint_reader

Reads the octave-1 keypoint BRAM after `find_keypoints` has filled it, decodes each packed entry into (x, y) coordinates, and streams them out over a valid/ready handshake. It sits on the read port of the keypoint BRAM, which `find_keypoints` writes through `O1key_write_addr`/`O1key_wea`/`O1_keypoint_out`. Its consumers are the downstream descriptor and readout logic. One instance is used per octave.

## Interface
- `DIMENSION`, 64: image width and height of the octave. `L = $clog2(DIMENSION)`.
- `ADDR_W`, `$clog2(DIMENSION*DIMENSION)`: keypoint BRAM address width.
- `clk` input, 1 bit: single clock; all logic is on its rising edge.
- `rst_in` input, 1 bit: reset, asynchronous and active-high.
- `start` input, 1 bit: one-cycle pulse that begins a readout. Ignored while `busy`.
- `keypoint_count` input, `ADDR_W+1` bits: number of BRAM entries to read. Sampled on the `start` cycle.
- `key_read_addr` output, `ADDR_W` bits: keypoint BRAM read address.
- `key_data` input, `2L+1` bits: BRAM read data. Valid 2 cycles after the address is driven (HIGH_PERFORMANCE BRAM).
- `kp_x` output, `L` bits: keypoint column.
- `kp_y` output, `L` bits: keypoint row.
- `kp_valid` output, 1 bit: `kp_x`/`kp_y` hold a keypoint.
- `kp_ready` input, 1 bit: consumer accepts the keypoint.
- `busy` output, 1 bit: high from the cycle after `start` until `done`.
- `done` output, 1 bit: one-cycle pulse when the readout completes.
- `emitted_count` output, `ADDR_W+1` bits: number of keypoints handed off in the current or last run.

## Operation
- Entry format (fixed):
  - bit `[2L]` is the present flag.
  - bits `[2L-1:L]` are y.
  - bits `[L-1:0]` are x.
- Entries with flag 0 are consumed but never presented.
- States:
  - IDLE: `busy=0`.
    - `start` with count 0 → DONE.
    - `start` with count > 0 → FETCH. Also latch the count, set addr=0 and clear `emitted_count`.
  - FETCH: `key_read_addr` driven → WAIT.
  - WAIT → CAPTURE.
  - CAPTURE: register `key_data`.
    - flag=1 → PRESENT.
    - flag=0 → ADVANCE.
  - PRESENT: `kp_valid=1`, with `kp_x`/`kp_y` held stable.
    - On `kp_valid & kp_ready`: increment `emitted_count` → ADVANCE.
  - ADVANCE:
    - If addr == count-1 → DONE.
    - Otherwise addr+1 → FETCH.
  - DONE: `done=1` for one cycle → IDLE.
- `key_read_addr` is held stable from FETCH through CAPTURE and holds its last value in IDLE.
- A `start` that arrives during any non-IDLE state is dropped. It is not queued.
- Counts larger than `DIMENSION*DIMENSION` are clamped to `DIMENSION*DIMENSION`.
- The address never wraps.

## Timing
- Reset values:
  - state IDLE
  - `key_read_addr=0`
  - `kp_x=0`, `kp_y=0`
  - `kp_valid=0`
  - `busy=0`
  - `done=0`
  - `emitted_count=0`
- `start` sampled high at edge 0:
  - FETCH drives address 0 in cycle 1.
  - Data is captured in cycle 3.
  - `kp_valid` is asserted in cycle 4.
- Minimum spacing between presented keypoints: 5 cycles (FETCH, WAIT, CAPTURE, PRESENT with `kp_ready` already high, ADVANCE).
- A skipped entry costs 4 cycles.
- `kp_valid`, once raised, stays high with unchanged data until accepted. It never drops without a handshake.
- With count 0, `done` pulses in cycle 1 and `busy` stays 0.
- `busy` is 1 in every state except IDLE and DONE. It drops in the same cycle that `done` pulses.
- If `rst_in` is asserted mid-operation, all outputs return to reset values immediately, regardless of clock. No `done` is issued for the aborted run.

## Test plan
- Count 0:
  - `start` with `keypoint_count=0` → `done` pulses in cycle 1.
  - `kp_valid` is never asserted and `emitted_count=0`.
- Three entries with `kp_ready` tied high, `DIMENSION=4`:
  - BRAM holds 0x1B, 0x10, 0x17.
  - Outputs are (x3,y2), (x0,y0), (x3,y1) in that order.
  - First `kp_valid` in cycle 4; `done` follows the third handshake; `emitted_count=3`.
- Backpressure:
  - Hold `kp_ready` low for 7 cycles on the first keypoint.
  - `kp_valid` and the data stay stable throughout, and the address does not advance.
  - Completion is delayed by exactly 7 cycles.
- Skip:
  - BRAM holds 0x0B, 0x1B.
  - Only (x3,y2) is emitted, `emitted_count=1`, and `done` follows.
- Reset mid-run:
  - Assert `rst_in` asynchronously while in PRESENT → `kp_valid`, `busy` and `emitted_count` are 0 before the next edge.
  - A fresh `start` then replays the run from address 0.
- Start while busy:
  - Pulse `start` again during WAIT.
  - The run is unaffected, there is a single `done`, and the state is IDLE afterwards.
